// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback result-select encodings and default widths.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH_DEF             = 32;
    localparam int unsigned PC_WIDTH_DEF               = 32;
    localparam int unsigned REGISTER_ADDRESS_WIDTH_DEF = 5;
    localparam int unsigned RETIRE_WIDTH_DEF           = 64;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10,
        RESULT_RSV = 2'b11
    } result_src_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: ALU result, load data or link address (PC+4).
module wb_result_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF
) (
    input  logic [1:0]            result_src_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    input  logic [PC_WIDTH-1:0]   pc_plus4_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0] pc_plus4_ext;

    // Link address is zero-extended or truncated to the register width.
    generate
        if (PC_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
            assign pc_plus4_ext = pc_plus4_i[DATA_WIDTH-1:0];
        end else begin : g_pc_zext
            assign pc_plus4_ext = {{(DATA_WIDTH-PC_WIDTH){1'b0}}, pc_plus4_i};
        end
    endgenerate

    // 3:1 select; the reserved encoding yields zero.
    always_comb begin
        result_o = '0;
        case (result_src_t'(result_src_i))
            RESULT_ALU: result_o = alu_result_i;
            RESULT_MEM: result_o = read_data_i;
            RESULT_PC4: result_o = pc_plus4_ext;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage consumer: result select, register-file commit with
// write-to-read bypass, retired-instruction counter and debug read port.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH             = DATA_WIDTH_DEF,
    parameter int unsigned PC_WIDTH               = PC_WIDTH_DEF,
    parameter int unsigned REGISTER_ADDRESS_WIDTH = REGISTER_ADDRESS_WIDTH_DEF,
    parameter int unsigned RETIRE_WIDTH           = RETIRE_WIDTH_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              ValidW_i,
    input  logic                              RegWriteW_i,
    input  logic [1:0]                        ResultSrcW_i,
    input  logic [DATA_WIDTH-1:0]             ALUResultW_i,
    input  logic [DATA_WIDTH-1:0]             ReadDataW_i,
    input  logic [PC_WIDTH-1:0]               PCPlus4W_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
    output logic [DATA_WIDTH-1:0]             RD1D_o,
    output logic [DATA_WIDTH-1:0]             RD2D_o,
    output logic [DATA_WIDTH-1:0]             ResultW_o,
    output logic [RETIRE_WIDTH-1:0]           RetireCount_o,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] DbgAddr_i,
    output logic [DATA_WIDTH-1:0]             DbgData_o
);

    localparam int unsigned NUM_REGS = 2 ** REGISTER_ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   result;
    logic                    write_en;
    logic [RETIRE_WIDTH-1:0] retire_q;

    wb_result_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_result_mux (
        .result_src_i (ResultSrcW_i),
        .alu_result_i (ALUResultW_i),
        .read_data_i  (ReadDataW_i),
        .pc_plus4_i   (PCPlus4W_i),
        .result_o     (result)
    );

    assign ResultW_o     = result;
    assign RetireCount_o = retire_q;

    // Bubbles never commit, and x0 is hard-wired to zero.
    assign write_en = ValidW_i & RegWriteW_i & (RdW_i != '0);

    // Architectural register storage; x0 is never written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[RdW_i] <= result;
        end
    end

    // Retired-instruction counter: every valid W instruction, wraps silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_q <= '0;
        end else if (ValidW_i) begin
            retire_q <= retire_q + RETIRE_WIDTH'(1);
        end
    end

    // Decode port 1: x0 reads zero, same-cycle W write bypasses storage.
    always_comb begin
        RD1D_o = regs[Rs1D_i];
        if (Rs1D_i == '0) begin
            RD1D_o = '0;
        end else if (write_en && (RdW_i == Rs1D_i)) begin
            RD1D_o = result;
        end
    end

    // Decode port 2: same rules as port 1.
    always_comb begin
        RD2D_o = regs[Rs2D_i];
        if (Rs2D_i == '0) begin
            RD2D_o = '0;
        end else if (write_en && (RdW_i == Rs2D_i)) begin
            RD2D_o = result;
        end
    end

    // Debug port: committed state only, no bypass.
    always_comb begin
        DbgData_o = regs[DbgAddr_i];
        if (DbgAddr_i == '0) begin
            DbgData_o = '0;
        end
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Consumer end of the Memory→Writeback pipeline interface.
- Selects the writeback result from the W-stage signals.
- Commits it to the 32-entry architectural register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Exports the result for E-stage forwarding, a retired-instruction counter and a debug read port.

Parameters:
DATA_WIDTH, 32, register and result width
PC_WIDTH, 32, width of PCPlus4W_i (zero-extended or truncated to DATA_WIDTH)
REGISTER_ADDRESS_WIDTH, 5, register index width; register count is 2**REGISTER_ADDRESS_WIDTH
RETIRE_WIDTH, 64, retired-instruction counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
ValidW_i  in  1  W stage holds a real (non-bubble) instruction
RegWriteW_i  in  1  write enable from W stage
ResultSrcW_i  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
ALUResultW_i  in  DATA_WIDTH  ALU result
ReadDataW_i  in  DATA_WIDTH  load data
PCPlus4W_i  in  PC_WIDTH  link address
RdW_i  in  REGISTER_ADDRESS_WIDTH  destination register
Rs1D_i  in  REGISTER_ADDRESS_WIDTH  decode read address 1
Rs2D_i  in  REGISTER_ADDRESS_WIDTH  decode read address 2
RD1D_o  out  DATA_WIDTH  read data 1
RD2D_o  out  DATA_WIDTH  read data 2
ResultW_o  out  DATA_WIDTH  selected writeback result, for the forwarding mux
RetireCount_o  out  RETIRE_WIDTH  retired-instruction count
DbgAddr_i  in  REGISTER_ADDRESS_WIDTH  debug read address
DbgData_o  out  DATA_WIDTH  debug read data; no bypass

Behaviour:
- Result mux (combinational):
  - ResultW_o = ALUResultW_i, ReadDataW_i or PCPlus4W_i for ResultSrcW_i = 00/01/10.
  - 11 → all zeros.
  - PCPlus4W_i is zero-extended or truncated to DATA_WIDTH.
- Commit:
  - Register commit requires WriteEn = ValidW_i & RegWriteW_i & (RdW_i != 0).
  - On the rising clk_i edge with WriteEn: regs[RdW_i] <= ResultW_o.
  - Latency 1 cycle: the stored value is visible from the next cycle.
- x0:
  - Never written; reads of index 0 always return 0 on all three ports, whatever the inputs.
- Decode reads (combinational):
  - RDn = 0 if Rsn == 0.
  - Else RDn = ResultW_o if WriteEn and RdW_i == Rsn.
  - Else RDn = regs[Rsn].
  - The bypass makes a same-cycle W write visible to D without an extra stall.
  - The bypass applies to both ports simultaneously, including Rs1D_i == Rs2D_i == RdW_i.
- Debug read: DbgData_o = regs[DbgAddr_i], with no bypass; index 0 returns 0.
- Retire counter:
  - Increments by 1 on every rising edge with ValidW_i = 1, whether or not RegWriteW_i is set (stores and branches retire).
  - Wraps modulo 2**RETIRE_WIDTH with no flag.
- Reset:
  - rst_i asserted asynchronously clears all registers and RetireCount_o to 0 immediately, regardless of clk_i.
  - While rst_i is high, no write or increment occurs.
  - Combinational outputs then reflect the zeroed state; ResultW_o still follows its inputs.
- Reset mid-operation: a write pending at the edge coincident with rst_i high is discarded.
- Invalid but RegWriteW_i = 1 (flushed bubble): no write, no bypass, no count.

Decomposition:
- Shared package (cpu_pkg): the ResultSrc encodings (RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10), the 2-bit result_src_t typedef, and the default width constants.
- One natural sub-module: wb_result_mux, the combinational 3:1 select, reused by the hazard/forwarding logic.
- Storage array, bypass and counter stay in wb_regfile.

Test Plan:
1. Reset: assert rst_i mid-cycle after writing x5=0x1234 → RD1D_o(Rs1=5)=0 and RetireCount_o=0 immediately, without waiting for a clock edge.
2. Write/read: Valid=1, RegWrite=1, Rd=7, Src=00, ALU=0xDEADBEEF → next cycle Rs1=7 gives 0xDEADBEEF; Src=01 with ReadData=0x55 to Rd=8 → x8=0x55; Src=10 with PC+4=0x104 to Rd=1 → x1=0x104.
3. Bypass: same cycle as writing 0xCAFEF00D to Rd=9, set Rs1=Rs2=9 → RD1D_o=RD2D_o=0xCAFEF00D before the edge; DbgData_o(9) shows the old value until after the edge.
4. x0: RegWrite to Rd=0 with ALU=0xFFFFFFFF → Rs1=0, Rs2=0 and Dbg=0 read 0, both same cycle and next cycle.
5. Bubble and reserved select: Valid=0, RegWrite=1, Rd=3 → x3 unchanged, no bypass, count unchanged; Valid=1, Src=11, Rd=4 → x4=0.
6. Counter: 10 valid cycles (3 with RegWrite=0) → RetireCount_o=10; preload near max via a RETIRE_WIDTH=4 build, 16 increments → wraps to 0.
